// File: rtl/store_buffer.sv
// Word-granular store buffer in front of a single-port data memory. Stores queue up and drain
// in free port cycles; loads get the port first and forward from the youngest queued store.
module store_buffer #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Aw    = 32,
  parameter int unsigned Dw    = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          st_valid_i,
  input  logic [Aw-1:0] st_addr_i,
  input  logic [Dw-1:0] st_data_i,
  output logic          st_ready_o,
  input  logic          ld_valid_i,
  input  logic [Aw-1:0] ld_addr_i,
  output logic          ld_ready_o,
  output logic [Dw-1:0] ld_data_o,
  output logic          sb_empty_o,
  output logic          mem_we_o,
  output logic [Aw-1:0] mem_a_o,
  output logic [Dw-1:0] mem_wd_o,
  input  logic [Dw-1:0] mem_rd_i
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Aw-1:0]    addr_q [Depth];
  logic [Dw-1:0]    data_q [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CntW-1:0]  count_q, count_d;

  logic            full;
  logic            enq;
  logic            drain;
  logic [PtrW-1:0] fwd_idx;

  assign full       = (count_q == CntW'(Depth));
  assign st_ready_o = !full;
  assign sb_empty_o = (count_q == '0);
  assign enq        = st_valid_i && !full;
  assign count_d    = count_q + CntW'(enq) - CntW'(drain);

  // A full queue must drain to make progress, so it takes the port even over a load.
  always_comb begin
    drain      = 1'b0;
    mem_we_o   = 1'b0;
    mem_a_o    = '0;
    mem_wd_o   = '0;
    ld_ready_o = !full;
    if (full || (!ld_valid_i && count_q != '0)) begin
      drain    = 1'b1;
      mem_we_o = 1'b1;
      mem_a_o  = addr_q[head_q];
      mem_wd_o = data_q[head_q];
    end else if (ld_valid_i) begin
      mem_a_o = ld_addr_i;
    end
  end

  // Walk oldest to youngest so the youngest word match overrides earlier ones.
  always_comb begin
    ld_data_o = mem_rd_i;
    fwd_idx   = head_q;
    for (int unsigned i = 0; i < Depth; i++) begin
      fwd_idx = head_q + PtrW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx][Aw-1:2] == ld_addr_i[Aw-1:2])) begin
        ld_data_o = data_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        addr_q[tail_q]  <= st_addr_i;
        data_q[tail_q]  <= st_data_i;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule
